hazard_ctrl: RTL and testbench

- Hazard and forwarding controller for the 5-stage pipeline.
- Drives the select lines of the forwarding muxes in ID (branch compare) and EX (ALU operands).
- Generates stall/flush for load-use and branch hazards.
- Sequences multi-cycle MULT/DIV operations in EX by freezing the front of the pipe with a cycle counter FSM.

---
 rtl/hazard_ctrl.sv | 108 ++++++++++
 tb/tb_hazard_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Hazard/forwarding control for the 5-stage pipe: combinational forward selects and stall/flush,
// plus a MULT/DIV sequencer that holds the front of the pipe for N+1 cycles and pulses md_done.
module hazard_ctrl #(
  parameter int REG_AW     = 5,
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] rsD,
  input  logic [REG_AW-1:0] rtD,
  input  logic [REG_AW-1:0] rsE,
  input  logic [REG_AW-1:0] rtE,
  input  logic [REG_AW-1:0] writeregE,
  input  logic [REG_AW-1:0] writeregM,
  input  logic [REG_AW-1:0] writeregW,
  input  logic              regwriteE,
  input  logic              regwriteM,
  input  logic              regwriteW,
  input  logic              memtoregE,
  input  logic              memtoregM,
  input  logic              branchD,
  input  logic              md_startE,
  input  logic              md_isdivE,
  output logic              forwardAD,
  output logic              forwardBD,
  output logic [1:0]        forwardAE,
  output logic [1:0]        forwardBE,
  output logic              stallF,
  output logic              stallD,
  output logic              stallE,
  output logic              flushE,
  output logic              md_busy,
  output logic              md_done
);

  localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          w_wrM_ok, w_wrW_ok, w_wrE_ok, w_ldM_ok;
  logic          w_lwstall, w_brstall, w_md_stall, w_hazard;

  // Register 0 is hard-wired zero, so a write to it must never be forwarded.
  assign w_wrM_ok = regwriteM && (writeregM != '0);
  assign w_wrW_ok = regwriteW && (writeregW != '0);
  assign w_wrE_ok = regwriteE && (writeregE != '0);
  assign w_ldM_ok = memtoregM && (writeregM != '0);

  assign forwardAE = (w_wrM_ok && writeregM == rsE) ? 2'b10 :
                     (w_wrW_ok && writeregW == rsE) ? 2'b01 : 2'b00;
  assign forwardBE = (w_wrM_ok && writeregM == rtE) ? 2'b10 :
                     (w_wrW_ok && writeregW == rtE) ? 2'b01 : 2'b00;
  assign forwardAD = (rsD != '0) && (rsD == writeregM) && regwriteM;
  assign forwardBD = (rtD != '0) && (rtD == writeregM) && regwriteM;

  assign w_lwstall = memtoregE && ((rtE == rsD) || (rtE == rtD));
  assign w_brstall = branchD &&
                     ((w_wrE_ok && ((writeregE == rsD) || (writeregE == rtD))) ||
                      (w_ldM_ok && ((writeregM == rsD) || (writeregM == rtD))));

  // Gated by rst so an aborted op releases the pipe even while md_startE is still high.
  assign w_md_stall = ~rst && (((r_state == S_IDLE) && md_startE) || (r_state == S_BUSY));
  assign w_hazard   = w_lwstall || w_brstall;

  assign stallF  = w_hazard || w_md_stall;
  assign stallD  = w_hazard || w_md_stall;
  assign stallE  = w_md_stall;
  assign flushE  = w_hazard && ~w_md_stall;
  assign md_busy = (r_state != S_IDLE);
  assign md_done = (r_state == S_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // A start seen in DONE belongs to the completing op and is deliberately ignored.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (md_startE) begin
          w_state_nxt = S_BUSY;
          w_cnt_nxt   = md_isdivE ? DIV_LOAD : MUL_LOAD;
        end
      end
      S_BUSY: begin
        if (r_cnt == '0) w_state_nxt = S_DONE;
        else             w_cnt_nxt   = r_cnt - CW'(1);
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: forwarding priority, load-use, branch, MULT/DIV sequencing, reset abort.
module tb_hazard_ctrl;
  localparam int AW = 5;

  logic          clk, rst;
  logic [AW-1:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
  logic          regwriteE, regwriteM, regwriteW, memtoregE, memtoregM;
  logic          branchD, md_startE, md_isdivE;
  logic          forwardAD, forwardBD;
  logic [1:0]    forwardAE, forwardBE;
  logic          stallF, stallD, stallE, flushE, md_busy, md_done;
  logic [5:0]    ctl;

  int n_tests = 0;
  int n_fail  = 0;

  hazard_ctrl #(.REG_AW(AW), .MUL_CYCLES(4), .DIV_CYCLES(32)) dut (
    .clk(clk), .rst(rst),
    .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
    .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
    .memtoregE(memtoregE), .memtoregM(memtoregM),
    .branchD(branchD), .md_startE(md_startE), .md_isdivE(md_isdivE),
    .forwardAD(forwardAD), .forwardBD(forwardBD),
    .forwardAE(forwardAE), .forwardBE(forwardBE),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .flushE(flushE),
    .md_busy(md_busy), .md_done(md_done)
  );

  // {stallF, stallD, stallE, flushE, md_busy, md_done}
  assign ctl = {stallF, stallD, stallE, flushE, md_busy, md_done};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    rsD = '0; rtD = '0; rsE = '0; rtE = '0;
    writeregE = '0; writeregM = '0; writeregW = '0;
    regwriteE = 1'b0; regwriteM = 1'b0; regwriteW = 1'b0;
    memtoregE = 1'b0; memtoregM = 1'b0; branchD = 1'b0;
    md_startE = 1'b0; md_isdivE = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    #2;
    n_tests++;
    if ({ctl, forwardAE, forwardBE, forwardAD, forwardBD} !== 12'h000) begin
      $display("FAIL reset_outputs got ctl=%b AE=%b BE=%b AD=%b BD=%b exp all 0",
               ctl, forwardAE, forwardBE, forwardAD, forwardBD);
      n_fail++;
    end
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (ctl !== 6'b000000) begin
      $display("FAIL reset_release_idle got %b exp 000000", ctl);
      n_fail++;
    end
  endtask

  task automatic test_forward();
    clear_inputs();
    regwriteM = 1'b1; writeregM = 5'd8; regwriteW = 1'b1; writeregW = 5'd8; rsE = 5'd8; rtE = 5'd9;
    #1;
    n_tests++;
    if ({forwardAE, forwardBE} !== 4'b1000) begin
      $display("FAIL fwd_mem_prio got AE=%b BE=%b exp AE=10 BE=00", forwardAE, forwardBE);
      n_fail++;
    end
    regwriteM = 1'b0;
    #1;
    n_tests++;
    if (forwardAE !== 2'b01) begin
      $display("FAIL fwd_wb got AE=%b exp 01", forwardAE);
      n_fail++;
    end
    regwriteM = 1'b1; rsE = '0; writeregM = '0; writeregW = '0;
    #1;
    n_tests++;
    if (forwardAE !== 2'b00) begin
      $display("FAIL fwd_r0 got AE=%b exp 00", forwardAE);
      n_fail++;
    end
    rsE = 5'd4; rtE = 5'd4; writeregM = 5'd4; writeregW = 5'd4;
    #1;
    n_tests++;
    if ({forwardAE, forwardBE} !== 4'b1010) begin
      $display("FAIL fwd_both_mem got AE=%b BE=%b exp 10 10", forwardAE, forwardBE);
      n_fail++;
    end
    rsE = 5'd2; rtE = 5'd6; writeregM = 5'd7; writeregW = 5'd6;
    #1;
    n_tests++;
    if ({forwardAE, forwardBE} !== 4'b0001) begin
      $display("FAIL fwd_be_wb got AE=%b BE=%b exp 00 01", forwardAE, forwardBE);
      n_fail++;
    end
    rsD = 5'd8; rtD = 5'd8; writeregM = 5'd8;
    #1;
    n_tests++;
    if ({forwardAD, forwardBD} !== 2'b11) begin
      $display("FAIL fwd_id got AD=%b BD=%b exp 1 1", forwardAD, forwardBD);
      n_fail++;
    end
    regwriteM = 1'b0;
    #1;
    n_tests++;
    if ({forwardAD, forwardBD} !== 2'b00) begin
      $display("FAIL fwd_id_nowr got AD=%b BD=%b exp 0 0", forwardAD, forwardBD);
      n_fail++;
    end
    regwriteM = 1'b1; rsD = '0; rtD = 5'd3; writeregM = '0;
    #1;
    n_tests++;
    if ({forwardAD, forwardBD, ctl} !== 8'h00) begin
      $display("FAIL fwd_id_r0 got AD=%b BD=%b ctl=%b exp all 0", forwardAD, forwardBD, ctl);
      n_fail++;
    end
    clear_inputs();
  endtask

  task automatic test_load_use();
    @(posedge clk); #1;
    clear_inputs();
    memtoregE = 1'b1; rtE = 5'd5; rsD = 5'd5; rtD = 5'd7;
    @(negedge clk);
    n_tests++;
    if (ctl !== 6'b110100) begin
      $display("FAIL load_use_stall got %b exp 110100", ctl);
      n_fail++;
    end
    @(posedge clk); #1;
    memtoregE = 1'b0;
    @(negedge clk);
    n_tests++;
    if (ctl !== 6'b000000) begin
      $display("FAIL load_use_release got %b exp 000000", ctl);
      n_fail++;
    end
    rtD = 5'd5; rsD = 5'd1; memtoregE = 1'b1;
    #1;
    n_tests++;
    if (ctl !== 6'b110100) begin
      $display("FAIL load_use_rt got %b exp 110100", ctl);
      n_fail++;
    end
    clear_inputs();
  endtask

  task automatic test_branch();
    @(posedge clk); #1;
    clear_inputs();
    branchD = 1'b1; regwriteE = 1'b1; writeregE = 5'd3; rtD = 5'd3;
    @(negedge clk);
    n_tests++;
    if (ctl !== 6'b110100) begin
      $display("FAIL branch_stall got %b exp 110100", ctl);
      n_fail++;
    end
    @(posedge clk); #1;
    regwriteE = 1'b0; writeregE = '0; regwriteM = 1'b1; writeregM = 5'd3;
    @(negedge clk);
    n_tests++;
    if ({ctl, forwardAD, forwardBD} !== 8'b00000001) begin
      $display("FAIL branch_fwd got ctl=%b AD=%b BD=%b exp 000000 0 1", ctl, forwardAD, forwardBD);
      n_fail++;
    end
    memtoregM = 1'b1;
    #1;
    n_tests++;
    if (ctl !== 6'b110100) begin
      $display("FAIL branch_load_mem got %b exp 110100", ctl);
      n_fail++;
    end
    clear_inputs();
  endtask

  // Op starts in cycle 1, BUSY cycles 2..N+1, DONE in cycle N+2.
  task automatic test_mult();
    logic [5:0] exp_ctl;
    @(posedge clk); #1;
    clear_inputs();
    md_startE = 1'b1; md_isdivE = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      exp_ctl = (c <= 5) ? {3'b111, 1'b0, (c >= 2), 1'b0} : 6'b000011;
      n_tests++;
      if (ctl !== exp_ctl) begin
        $display("FAIL mult_cycle%0d got %b exp %b", c, ctl, exp_ctl);
        n_fail++;
      end
      @(posedge clk); #1;
    end
    md_startE = 1'b0;
    @(negedge clk);
    n_tests++;
    if (ctl !== 6'b000000) begin
      $display("FAIL mult_idle got %b exp 000000", ctl);
      n_fail++;
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] exp_ctl;
    int k;
    @(posedge clk); #1;
    clear_inputs();
    md_startE = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      k = ((c - 1) % 6) + 1;
      exp_ctl = (k <= 5) ? {3'b111, 1'b0, (k >= 2), 1'b0} : 6'b000011;
      n_tests++;
      if (ctl !== exp_ctl) begin
        $display("FAIL b2b_cycle%0d got %b exp %b", c, ctl, exp_ctl);
        n_fail++;
      end
      @(posedge clk); #1;
    end
    md_startE = 1'b0;
    @(negedge clk);
    n_tests++;
    if (ctl !== 6'b000000) begin
      $display("FAIL b2b_idle got %b exp 000000", ctl);
      n_fail++;
    end
  endtask

  task automatic test_div_load_use();
    logic [5:0] exp_ctl;
    @(posedge clk); #1;
    clear_inputs();
    md_startE = 1'b1; md_isdivE = 1'b1; memtoregE = 1'b1; rtE = 5'd5; rsD = 5'd5;
    for (int c = 1; c <= 34; c++) begin
      @(negedge clk);
      exp_ctl = (c <= 33) ? {3'b111, 1'b0, (c >= 2), 1'b0} : 6'b110111;
      n_tests++;
      if (ctl !== exp_ctl) begin
        $display("FAIL div_cycle%0d got %b exp %b", c, ctl, exp_ctl);
        n_fail++;
      end
      @(posedge clk); #1;
    end
    clear_inputs();
    @(negedge clk);
    n_tests++;
    if (ctl !== 6'b000000) begin
      $display("FAIL div_idle got %b exp 000000", ctl);
      n_fail++;
    end
  endtask

  task automatic test_reset_busy();
    @(posedge clk); #1;
    clear_inputs();
    md_startE = 1'b1; md_isdivE = 1'b1;
    for (int i = 0; i < 22; i++) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    n_tests++;
    if (ctl !== 6'b111010) begin
      $display("FAIL rst_busy_pre got %b exp 111010", ctl);
      n_fail++;
    end
    #1 rst = 1'b1;
    #1;
    n_tests++;
    if (ctl !== 6'b000000) begin
      $display("FAIL rst_busy_abort got %b exp 000000", ctl);
      n_fail++;
    end
    md_startE = 1'b0;
    #1 rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_tests++;
      if (ctl !== 6'b000000) begin
        $display("FAIL rst_after%0d got %b exp 000000", c, ctl);
        n_fail++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_load_use();
    test_branch();
    test_mult();
    test_back_to_back();
    test_div_load_use();
    test_reset_busy();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
